prio_scan_enc: RTL

PRIO_SCAN_ENC -- requirements
Module: prio_scan_enc

---
 rtl/prio_scan_enc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/prio_scan_enc.sv
// Priority scan encoder: captures a request vector, then hands out its set-bit indices one per
// Valid/Ready handshake. Define PRIO_LSB_FIRST_EN for ascending grant order (default: MSB first).
module prio_scan_enc #(
   parameter int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         CLK,
   input  logic         RST_n,
   input  logic         EN,
   input  logic         Start,
   input  logic [N-1:0] In,
   input  logic         Ready,
   output logic [W-1:0] Y,
   output logic         Valid,
   output logic         Busy,
   output logic         Done,
   output logic         None
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t         r_state;
   logic [N-1:0]   r_mask;
   logic [W-1:0]   r_y;
   logic           r_valid;
   logic           r_busy;
   logic           r_done;
   logic           r_none;
   logic           r_zero;

   logic           w_take;
   logic [N-1:0]   w_bit;
   logic [N-1:0]   w_mask_next;
   logic [W-1:0]   w_pick_in;
   logic [W-1:0]   w_pick_next;

   // Index of the bit that is granted first from vector m.
   function automatic logic [W-1:0] f_pick(input logic [N-1:0] m);
      logic [W-1:0] idx;
      idx = '0;
`ifdef PRIO_LSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--) begin
         if (m[i]) idx = W'(i);
      end
`else
      for (int i = 0; i < N; i++) begin
         if (m[i]) idx = W'(i);
      end
`endif
      return idx;
   endfunction

   // Only a handshake actually presented to the consumer clears a bit.
   assign w_take      = r_valid & Ready;
   assign w_bit       = N'(1) << r_y;
   assign w_mask_next = w_take ? (r_mask & ~w_bit) : r_mask;
   assign w_pick_in   = f_pick(In);
   assign w_pick_next = f_pick(w_mask_next);

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state <= S_IDLE;
         r_mask  <= '0;
         r_y     <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_none  <= 1'b0;
         r_zero  <= 1'b0;
      end else if (EN) begin
         r_done <= 1'b0;
         r_none <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_mask <= In;
                  r_zero <= (In == '0);
                  if (In != '0) begin
                     r_state <= S_SCAN;
                     r_valid <= 1'b1;
                     r_y     <= w_pick_in;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= S_FIN;
                  end
               end
            end
            S_SCAN: begin
               r_mask <= w_mask_next;
               if (w_mask_next == '0) begin
                  r_state <= S_FIN;
                  r_valid <= 1'b0;
                  r_y     <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_valid <= 1'b1;
                  r_y     <= w_pick_next;
               end
            end
            S_FIN: begin
               r_done  <= 1'b1;
               r_none  <= r_zero;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_y     <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end else begin
         // Frozen: state and mask hold, the index is re-derived from the mask on resume.
         r_valid <= 1'b0;
         r_y     <= '0;
         r_done  <= 1'b0;
         r_none  <= 1'b0;
      end
   end

   assign Y     = r_y;
   assign Valid = r_valid;
   assign Busy  = r_busy;
   assign Done  = r_done;
   assign None  = r_none;

endmodule
